dfr_batch_sequencer: RTL
========================

// Module: dfr_batch_sequencer
// PURPOSE
//  Sequences the DFR core over a run of num_batches back-to-back inferences without host intervention.
//  Per batch: waits for the input buffer bank to be loaded, pulses the core start, then watches the core busy
//  handshake, emits a result strobe and flips the ping-pong bank. Optionally preserves reservoir state across
//  batches, guards each run with a watchdog, and supports host abort. Sits between the AXI register file and the core.
// PARAMETERS
//  CNT_W   16  width of batch count / result index
//  TMO_W   24  width of per-run watchdog limit
// PORTS
//  clk               in   1      system clock; all logic on rising edge
//  rst               in   1      reset, asynchronous, active-high
//  start             in   1      begin sequence (sampled only in IDLE)
//  abort             in   1      cancel sequence (any non-IDLE state)
//  num_batches       in   CNT_W  batches to run; latched on accepted start
//  preserve_between  in   1      keep reservoir between batches; latched on start
//  timeout_cycles    in   TMO_W  per-run watchdog limit; 0 = disabled; latched on start
//  batch_ready       in   1      current input bank loaded by host/DMA (level)
//  core_busy         in   1      core busy flag
//  core_start        out  1      1-cycle start pulse to core
//  core_preserve     out  1      preserve_reservoir to core, valid while core_start high
//  core_rst          out  1      1-cycle core reset pulse (abort/timeout)
//  bank_sel          out  1      ping-pong input/result bank in use
//  batch_ack         out  1      1-cycle: current bank consumed, host may refill
//  result_valid      out  1      1-cycle: core finished batch result_idx
//  result_idx        out  CNT_W  index of finished batch, held until next strobe
//  busy              out  1      high in every state except IDLE
//  seq_done          out  1      1-cycle: sequence completed normally (or num_batches==0)
//  error             out  1      sticky timeout flag; cleared on next accepted start
//  aborted           out  1      sticky abort flag; cleared on next accepted start
//  state_out         out  3      current state encoding, debug
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0, bank_sel 0. Applies immediately; a reset mid-run drops
//    everything, issues no core_rst pulse (core shares rst).
//  - States (3-bit): IDLE=0, WAIT_DATA=1, LAUNCH=2, WAIT_ACCEPT=3, RUN=4.
//  - IDLE: start && num_batches!=0 -> latch config, batch_cnt=0, clear error/aborted -> WAIT_DATA.
//    start && num_batches==0 -> seq_done pulse next cycle, stay IDLE.
//  - WAIT_DATA: batch_ready -> LAUNCH. No timeout here.
//  - LAUNCH (exactly 1 cycle): core_start=1; core_preserve = preserve_latched && batch_cnt!=0;
//    watchdog cleared -> WAIT_ACCEPT.
//  - WAIT_ACCEPT: core_busy==1 -> RUN (core asserts busy 1 cycle after start).
//  - RUN: core_busy==0 -> result_valid=1, result_idx=batch_cnt, batch_ack=1, bank_sel toggles, batch_cnt++;
//    if batch_cnt==num_latched-1 -> seq_done=1, IDLE; else WAIT_DATA.
//  - Strobe outputs (core_start, core_rst, batch_ack, result_valid, seq_done) are registered, single-cycle.
//  - Watchdog: counts every cycle in WAIT_ACCEPT and RUN; when count==timeout_latched (nonzero) ->
//    core_rst pulse, error=1, IDLE; no result_valid for that batch.
//  - abort in any non-IDLE state -> core_rst pulse, aborted=1, IDLE next cycle. Priority:
//    abort > timeout > completion. start while busy is ignored; abort in IDLE ignored.
//  - batch_cnt compare uses latched CNT_W values; max run 2^CNT_W-1 batches, no wrap.
//  - bank_sel not reset by start; it continues alternating across sequences.
// STRUCTURE
//  - dfr_pkg: state enum, default CNT_W/TMO_W constants.
//  - Sub-module dfr_watchdog_timer (clear, en, limit, expired); remainder is one FSM + counters.
// TESTING
//  - num=3, preserve=1, batch_ready=1, core model busy 10 cycles -> 3 core_start pulses;
//    core_preserve 0,1,1; result_idx 0,1,2; bank_sel 0->1->0->1; one seq_done.
//  - num=0, start -> seq_done 1 cycle later, busy stays 0, no core_start.
//  - timeout=5, core holds busy 20 cycles -> core_rst once, error=1, IDLE, no result_valid;
//    next start clears error.
//  - batch_ready low 50 cycles between batches -> no core_start until ready; no timeout.
//  - abort in RUN on the same cycle core_busy falls -> core_rst, aborted=1, no result_valid.
//  - rst asserted mid-RUN (asynchronous, between edges) -> all outputs 0 immediately, state_out=0.

Source files
------------

// File: rtl/dfr_pkg.sv
// Shared types and default widths for the DFR batch sequencer slice.
package dfr_pkg;

   localparam int CNT_W_DEF = 16;
   localparam int TMO_W_DEF = 24;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_WAIT_DATA   = 3'd1,
      ST_LAUNCH      = 3'd2,
      ST_WAIT_ACCEPT = 3'd3,
      ST_RUN         = 3'd4
   } seq_state_e;

endpackage

// File: rtl/dfr_watchdog_timer.sv
// Per-run watchdog: counts enabled cycles since the last clear and flags when the limit is reached.
module dfr_watchdog_timer #(
   parameter int TMO_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   input  logic [TMO_W-1:0] limit,
   output logic             expired
);

   logic [TMO_W-1:0] count_r;

   // Cycle counter; saturates so a disabled (zero) limit never wraps into a false match.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= {TMO_W{1'b0}};
      end else if (clear) begin
         count_r <= {TMO_W{1'b0}};
      end else if (en && (count_r != {TMO_W{1'b1}})) begin
         count_r <= count_r + {{(TMO_W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = en && (limit != {TMO_W{1'b0}}) && (count_r == limit);

endmodule

// File: rtl/dfr_batch_sequencer.sv
// Runs the DFR core over num_batches back-to-back inferences with ping-pong banking,
// watchdog protection and host abort.
module dfr_batch_sequencer
   import dfr_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int TMO_W = TMO_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] num_batches,
   input  logic             preserve_between,
   input  logic [TMO_W-1:0] timeout_cycles,
   input  logic             batch_ready,
   input  logic             core_busy,
   output logic             core_start,
   output logic             core_preserve,
   output logic             core_rst,
   output logic             bank_sel,
   output logic             batch_ack,
   output logic             result_valid,
   output logic [CNT_W-1:0] result_idx,
   output logic             busy,
   output logic             seq_done,
   output logic             error,
   output logic             aborted,
   output logic [2:0]       state_out
);

   seq_state_e       state_r;
   seq_state_e       state_nxt_s;
   logic [CNT_W-1:0] num_r;
   logic [CNT_W-1:0] batch_cnt_r;
   logic             preserve_r;
   logic [TMO_W-1:0] timeout_r;
   logic             accept_s;
   logic             empty_done_s;
   logic             batch_done_s;
   logic             last_s;
   logic             abort_hit_s;
   logic             tmo_hit_s;
   logic             wd_clear_s;
   logic             wd_en_s;
   logic             wd_expired_s;

   assign wd_clear_s = (state_r == ST_LAUNCH);
   assign wd_en_s    = (state_r == ST_WAIT_ACCEPT) || (state_r == ST_RUN);
   assign last_s     = (batch_cnt_r == (num_r - {{(CNT_W-1){1'b0}}, 1'b1}));
   assign state_out  = state_r;

   dfr_watchdog_timer #(.TMO_W(TMO_W)) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear_s),
      .en      (wd_en_s),
      .limit   (timeout_r),
      .expired (wd_expired_s)
   );

   // Next-state logic; abort outranks the watchdog, which outranks normal completion.
   always_comb begin
      state_nxt_s  = state_r;
      accept_s     = 1'b0;
      empty_done_s = 1'b0;
      batch_done_s = 1'b0;
      abort_hit_s  = 1'b0;
      tmo_hit_s    = 1'b0;
      if ((state_r != ST_IDLE) && abort) begin
         abort_hit_s = 1'b1;
         state_nxt_s = ST_IDLE;
      end else if (wd_expired_s) begin
         tmo_hit_s   = 1'b1;
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  if (num_batches != {CNT_W{1'b0}}) begin
                     accept_s    = 1'b1;
                     state_nxt_s = ST_WAIT_DATA;
                  end else begin
                     empty_done_s = 1'b1;
                  end
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_WAIT_DATA: begin
               if (batch_ready) begin
                  state_nxt_s = ST_LAUNCH;
               end else begin
                  state_nxt_s = ST_WAIT_DATA;
               end
            end
            ST_LAUNCH: begin
               state_nxt_s = ST_WAIT_ACCEPT;
            end
            ST_WAIT_ACCEPT: begin
               if (core_busy) begin
                  state_nxt_s = ST_RUN;
               end else begin
                  state_nxt_s = ST_WAIT_ACCEPT;
               end
            end
            ST_RUN: begin
               if (!core_busy) begin
                  batch_done_s = 1'b1;
                  state_nxt_s  = last_s ? ST_IDLE : ST_WAIT_DATA;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // State register and single-cycle strobes, all aligned with the state they belong to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         busy          <= 1'b0;
         core_start    <= 1'b0;
         core_preserve <= 1'b0;
         core_rst      <= 1'b0;
         batch_ack     <= 1'b0;
         result_valid  <= 1'b0;
         seq_done      <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         busy          <= (state_nxt_s != ST_IDLE);
         core_start    <= (state_nxt_s == ST_LAUNCH);
         core_preserve <= (state_nxt_s == ST_LAUNCH) && preserve_r &&
                          (batch_cnt_r != {CNT_W{1'b0}});
         core_rst      <= abort_hit_s || tmo_hit_s;
         batch_ack     <= batch_done_s;
         result_valid  <= batch_done_s;
         seq_done      <= empty_done_s || (batch_done_s && last_s);
      end
   end

   // Run configuration captured on an accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         num_r      <= {CNT_W{1'b0}};
         preserve_r <= 1'b0;
         timeout_r  <= {TMO_W{1'b0}};
      end else if (accept_s) begin
         num_r      <= num_batches;
         preserve_r <= preserve_between;
         timeout_r  <= timeout_cycles;
      end else begin
         num_r      <= num_r;
         preserve_r <= preserve_r;
         timeout_r  <= timeout_r;
      end
   end

   // Batch bookkeeping; bank_sel keeps alternating across sequences.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         batch_cnt_r <= {CNT_W{1'b0}};
         result_idx  <= {CNT_W{1'b0}};
         bank_sel    <= 1'b0;
      end else if (accept_s) begin
         batch_cnt_r <= {CNT_W{1'b0}};
         result_idx  <= result_idx;
         bank_sel    <= bank_sel;
      end else if (batch_done_s) begin
         batch_cnt_r <= batch_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         result_idx  <= batch_cnt_r;
         bank_sel    <= ~bank_sel;
      end else begin
         batch_cnt_r <= batch_cnt_r;
         result_idx  <= result_idx;
         bank_sel    <= bank_sel;
      end
   end

   // Sticky status flags, cleared when a new sequence is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         error   <= 1'b0;
         aborted <= 1'b0;
      end else if (accept_s) begin
         error   <= 1'b0;
         aborted <= 1'b0;
      end else begin
         error   <= error || tmo_hit_s;
         aborted <= aborted || abort_hit_s;
      end
   end

endmodule
